// File: rtl/txpi_pkg.sv
// Shared types and helpers for the TX phase-interpolator step sequencer.
package txpi_pkg;

  localparam int unsigned TXPI_MAG_W  = 4;
  localparam int unsigned TXPI_CODE_W = TXPI_MAG_W + 1;

  localparam logic TXPI_DIR_ADV = 1'b0;
  localparam logic TXPI_DIR_RET = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } txpi_state_e;

  // TXPIPPMSTEPSIZE layout: direction in the MSB, magnitude below it
  function automatic logic [TXPI_CODE_W-1:0] txpi_encode(input logic dir,
                                                          input logic [TXPI_MAG_W-1:0] mag);
    return {dir, mag};
  endfunction

endpackage

// File: rtl/txpi_step_sequencer_if.sv
// Request/status bundle between the phase-error logic and the PI step sequencer.
interface txpi_step_sequencer_if #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned TOT_W = 24
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic signed [ACC_W-1:0] req_steps;
  logic                    abort;
  logic                    clr_total;
  logic                    busy;
  logic                    done;
  logic [4:0]              txpippmstepsize;
  logic                    txpippmen;
  logic                    txpippmsel;
  logic signed [TOT_W-1:0] total_steps;
  logic                    sat;

  modport master (
    output req_valid, req_steps, abort, clr_total,
    input  req_ready, busy, done, txpippmstepsize, txpippmen, txpippmsel,
           total_steps, sat
  );

  modport slave (
    input  req_valid, req_steps, abort, clr_total,
    output req_ready, busy, done, txpippmstepsize, txpippmen, txpippmsel,
           total_steps, sat
  );

endinterface

// File: rtl/txpi_sat_acc.sv
// Signed saturating accumulator of applied PI steps with sticky saturation flag.
module txpi_sat_acc
  import txpi_pkg::*;
#(
  parameter int unsigned TOT_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_add,
  input  logic                    i_dir,
  input  logic [TXPI_MAG_W-1:0]   i_mag,
  output logic signed [TOT_W-1:0] o_total,
  output logic                    o_sat
);

  localparam int unsigned EXT_W = TOT_W + 1;

  logic signed [TOT_W-1:0] r_total;
  logic                    r_sat;
  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_delta;
  logic signed [EXT_W-1:0] w_sum;
  logic                    w_ovf;
  logic [TOT_W-1:0]        w_clamp;

  // One guard bit: overflow shows up as disagreement between the top two bits
  always_comb begin
    w_ext   = {r_total[TOT_W-1], r_total};
    w_delta = i_dir ? -(EXT_W'(i_mag)) : EXT_W'(i_mag);
    w_sum   = w_ext + w_delta;
    w_ovf   = w_sum[EXT_W-1] ^ w_sum[EXT_W-2];
    w_clamp = w_sum[EXT_W-1] ? {1'b1, {(TOT_W-1){1'b0}}} : {1'b0, {(TOT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total <= '0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_total <= '0;
      r_sat   <= 1'b0;
    end else if (i_add) begin
      if (w_ovf) begin
        r_total <= w_clamp;
        r_sat   <= 1'b1;
      end else begin
        r_total <= w_sum[TOT_W-1:0];
      end
    end
  end

  assign o_total = r_total;
  assign o_sat   = r_sat;

endmodule

// File: rtl/txpi_step_sequencer.sv
// Splits signed phase-correction requests into bounded TXPIPPM steps separated
// by a hold-off, and keeps a saturating running total of applied steps.
module txpi_step_sequencer
  import txpi_pkg::*;
#(
  parameter int unsigned MAX_STEP = 15,
  parameter int unsigned HOLDOFF  = 4,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned TOT_W    = 24
) (
  input logic                  clk,
  input logic                  rst,
  txpi_step_sequencer_if.slave bus
);

  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  txpi_state_e              r_state;
  txpi_state_e              w_state_nxt;
  logic [ACC_W-1:0]         r_remaining;
  logic [ACC_W-1:0]         w_remaining_nxt;
  logic [HOLD_W-1:0]        r_hold;
  logic [HOLD_W-1:0]        w_hold_nxt;
  logic                     r_dir;
  logic                     w_dir_nxt;
  logic [TXPI_CODE_W-1:0]   r_stepsize;
  logic [TXPI_CODE_W-1:0]   w_stepsize_nxt;
  logic                     r_done;
  logic                     w_done_nxt;
  logic [TXPI_MAG_W-1:0]    w_mag;
  logic [ACC_W-1:0]         w_req_abs;
  logic                     w_req_ready;
  logic                     w_accept;
  logic                     w_req_zero;
  logic                     w_hold_exp;

  function automatic logic [TXPI_MAG_W-1:0] f_step_mag(input logic [ACC_W-1:0] v);
    return (v > ACC_W'(MAX_STEP)) ? TXPI_MAG_W'(MAX_STEP) : TXPI_MAG_W'(v);
  endfunction

  // Magnitude is held unsigned so the most negative request converts exactly
  assign w_req_abs   = bus.req_steps[ACC_W-1] ? ACC_W'(-bus.req_steps) : ACC_W'(bus.req_steps);
  assign w_req_zero  = (bus.req_steps == '0);
  assign w_req_ready = (r_state == IDLE) && !bus.abort;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_hold_exp  = (r_hold == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && !w_req_zero) w_state_nxt = STEP;
      STEP: w_state_nxt = bus.abort ? IDLE : HOLD;
      HOLD: begin
        if (bus.abort)       w_state_nxt = IDLE;
        else if (w_hold_exp) w_state_nxt = (r_remaining != '0) ? STEP : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; a step code is loaded on the edge entering STEP
  always_comb begin
    w_stepsize_nxt  = '0;
    w_done_nxt      = 1'b0;
    w_remaining_nxt = r_remaining;
    w_hold_nxt      = r_hold;
    w_dir_nxt       = r_dir;
    w_mag           = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_zero) begin
            w_done_nxt = 1'b1;
          end else begin
            w_dir_nxt       = bus.req_steps[ACC_W-1] ? TXPI_DIR_RET : TXPI_DIR_ADV;
            w_mag           = f_step_mag(w_req_abs);
            w_stepsize_nxt  = txpi_encode(w_dir_nxt, w_mag);
            w_remaining_nxt = w_req_abs - ACC_W'(w_mag);
          end
        end
      end
      STEP: begin
        if (bus.abort) begin
          w_remaining_nxt = '0;
          w_done_nxt      = 1'b1;
        end else begin
          w_hold_nxt = HOLD_W'(HOLDOFF - 1);
        end
      end
      HOLD: begin
        if (bus.abort) begin
          w_remaining_nxt = '0;
          w_done_nxt      = 1'b1;
        end else if (w_hold_exp) begin
          if (r_remaining != '0) begin
            w_mag           = f_step_mag(r_remaining);
            w_stepsize_nxt  = txpi_encode(r_dir, w_mag);
            w_remaining_nxt = r_remaining - ACC_W'(w_mag);
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_hold_nxt = r_hold - 1'b1;
        end
      end
      default: w_remaining_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stepsize  <= '0;
      r_done      <= 1'b0;
      r_remaining <= '0;
      r_hold      <= '0;
      r_dir       <= TXPI_DIR_ADV;
    end else begin
      r_stepsize  <= w_stepsize_nxt;
      r_done      <= w_done_nxt;
      r_remaining <= w_remaining_nxt;
      r_hold      <= w_hold_nxt;
      r_dir       <= w_dir_nxt;
    end
  end

  // The step shown during STEP is counted on the edge that ends it
  txpi_sat_acc #(
    .TOT_W (TOT_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.clr_total),
    .i_add   (r_state == STEP),
    .i_dir   (r_stepsize[TXPI_CODE_W-1]),
    .i_mag   (r_stepsize[TXPI_MAG_W-1:0]),
    .o_total (bus.total_steps),
    .o_sat   (bus.sat)
  );

  assign bus.req_ready       = w_req_ready;
  assign bus.busy            = (r_state != IDLE);
  assign bus.done            = r_done;
  assign bus.txpippmstepsize = r_stepsize;
  assign bus.txpippmen       = 1'b1;
  assign bus.txpippmsel      = 1'b1;

endmodule

// File: tb/tb_txpi_step_sequencer.sv
// Scoreboard bench for txpi_step_sequencer: expected step codes/cycles and done
// pulses are queued when a request is driven and popped as the DUT emits them.
module tb_txpi_step_sequencer;

  localparam int unsigned MAX_STEP = 15;
  localparam int unsigned HOLDOFF  = 4;

  typedef struct {
    int         cyc;
    logic [4:0] code;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_total = 0;

  step_t step_q[$];
  int    done_q[$];

  txpi_step_sequencer_if #(.ACC_W(16), .TOT_W(24)) bus ();
  txpi_step_sequencer_if #(.ACC_W(16), .TOT_W(8))  bus8 ();

  txpi_step_sequencer #(
    .MAX_STEP (MAX_STEP), .HOLDOFF (HOLDOFF), .ACC_W (16), .TOT_W (24)
  ) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  txpi_step_sequencer #(
    .MAX_STEP (MAX_STEP), .HOLDOFF (HOLDOFF), .ACC_W (16), .TOT_W (8)
  ) dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every nonzero step and every done pulse must be expected
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.txpippmstepsize != 5'd0) begin
        if (step_q.size() == 0) begin
          check_eq("unexpected_step", longint'(bus.txpippmstepsize), 0);
        end else begin
          step_t e;
          e = step_q.pop_front();
          check_eq("step_cycle", cyc, e.cyc);
          check_eq("step_code", longint'(bus.txpippmstepsize), longint'(e.code));
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          int d;
          d = done_q.pop_front();
          check_eq("done_cycle", cyc, d);
        end
      end
    end
  end

  // mode 0: full request; 1: aborted after first step (done two cycles after accept); 2: first step only
  task automatic push_model(input int v, input int acc, input int mode);
    int rem, m, t;
    logic neg;
    neg = (v < 0);
    rem = neg ? -v : v;
    t   = acc;
    while (rem > 0) begin
      m = (rem > int'(MAX_STEP)) ? int'(MAX_STEP) : rem;
      step_q.push_back('{t, {neg, 4'(m)}});
      if (mode != 2) exp_total += neg ? -m : m;
      rem -= m;
      t   += int'(HOLDOFF) + 1;
      if (mode != 0) break;
    end
    if (mode == 0) done_q.push_back(t);
    if (mode == 1) done_q.push_back(acc + 2);
  endtask

  // Returns at the negedge just after the accepting edge (state STEP if nonzero)
  task automatic drive_req(input int v, input int mode, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready", longint'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_steps = 16'(v);
    acc = cyc + 1;
    push_model(v, acc, mode);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_steps = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((step_q.size() != 0 || done_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, longint'(n < budget), 1);
    step_q.delete();
    done_q.delete();
  endtask

  task automatic clr_main();
    @(negedge clk);
    bus.clr_total = 1'b1;
    @(negedge clk);
    bus.clr_total = 1'b0;
    exp_total = 0;
    check_eq("clr_total", longint'(bus.total_steps), 0);
  endtask

  task automatic drive8(input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus8.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus8.req_valid = 1'b1;
    bus8.req_steps = 16'(v);
    @(negedge clk);
    bus8.req_valid = 1'b0;
    n = 0;
    while (bus8.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("b8_idle", longint'(bus8.busy), 0);
  endtask

  initial begin
    int acc;
    bus.req_valid  = 1'b0; bus.req_steps  = '0; bus.abort  = 1'b0; bus.clr_total  = 1'b0;
    bus8.req_valid = 1'b0; bus8.req_steps = '0; bus8.abort = 1'b0; bus8.clr_total = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_stepsize", longint'(bus.txpippmstepsize), 0);
    check_eq("rst_done", longint'(bus.done), 0);
    check_eq("rst_total", longint'(bus.total_steps), 0);
    check_eq("rst_sat", longint'(bus.sat), 0);
    check_eq("rst_busy", longint'(bus.busy), 0);
    check_eq("rst_ready", longint'(bus.req_ready), 1);
    check_eq("pippm_en", longint'(bus.txpippmen), 1);
    check_eq("pippm_sel", longint'(bus.txpippmsel), 1);
    rst = 1'b0;

    // +40: 15, 15, 10 spaced HOLDOFF+1 apart
    drive_req(40, 0, acc);
    check_eq("busy_step", longint'(bus.busy), 1);
    wait_idle("t1_drain", 200);
    check_eq("t1_total", longint'(bus.total_steps), exp_total);

    clr_main();
    drive_req(-17, 0, acc);
    wait_idle("t2a_drain", 200);
    check_eq("t2a_total", longint'(bus.total_steps), exp_total);
    drive_req(40, 0, acc);
    wait_idle("t2b_drain", 200);
    check_eq("t2b_total", longint'(bus.total_steps), exp_total);

    // zero request: done next cycle, never busy
    drive_req(0, 0, acc);
    check_eq("t3_busy", longint'(bus.busy), 0);
    wait_idle("t3_drain", 50);
    check_eq("t3_total", longint'(bus.total_steps), exp_total);

    // abort during the first hold cycle
    drive_req(40, 1, acc);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("t4_busy", longint'(bus.busy), 0);
    repeat (8) @(negedge clk);
    check_eq("t4_q_empty", longint'(step_q.size() + done_q.size()), 0);
    check_eq("t4_total", longint'(bus.total_steps), exp_total);

    // clear coincident with a STEP cycle drops that step
    drive_req(40, 0, acc);
    bus.clr_total = 1'b1;
    @(negedge clk);
    bus.clr_total = 1'b0;
    wait_idle("t5_drain", 200);
    check_eq("t5_clr_vs_step", longint'(bus.total_steps), 25);

    clr_main();
    drive_req(-32768, 0, acc);
    wait_idle("t6_drain", 12000);
    check_eq("t6_total", longint'(bus.total_steps), -32768);

    // 8-bit total saturates high and is cleared
    drive8(100);
    check_eq("t7_total_a", longint'(bus8.total_steps), 100);
    check_eq("t7_sat_a", longint'(bus8.sat), 0);
    drive8(100);
    check_eq("t7_total_b", longint'(bus8.total_steps), 127);
    check_eq("t7_sat_b", longint'(bus8.sat), 1);
    @(negedge clk);
    bus8.clr_total = 1'b1;
    @(negedge clk);
    bus8.clr_total = 1'b0;
    check_eq("t7_clr_total", longint'(bus8.total_steps), 0);
    check_eq("t7_clr_sat", longint'(bus8.sat), 0);

    // asynchronous reset in the middle of a hold
    clr_main();
    drive_req(40, 2, acc);
    @(negedge clk);
    check_eq("t8_pre_total", longint'(bus.total_steps), 15);
    check_eq("t8_pre_busy", longint'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t8_rst_busy", longint'(bus.busy), 0);
    check_eq("t8_rst_total", longint'(bus.total_steps), 0);
    check_eq("t8_rst_step", longint'(bus.txpippmstepsize), 0);
    check_eq("t8_rst_done", longint'(bus.done), 0);
    check_eq("t8_rst_sat", longint'(bus.sat), 0);
    check_eq("t8_rst_ready", longint'(bus.req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    exp_total = 0;
    drive_req(1, 0, acc);
    wait_idle("t8_post_drain", 100);
    check_eq("t8_post_total", longint'(bus.total_steps), exp_total);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
